// File: rtl/simon_input_checker_if.sv
// Game-controller and sequence-memory signals of the Simon player input checker.
// The checker itself connects through the slave modport.
interface simon_input_checker_if #(
    parameter int ADDR_W = 4
) ();
    logic              start;
    logic [4:0]        round_len;
    logic [ADDR_W-1:0] seq_addr;
    logic [1:0]        seq_data;
    logic              press_valid;
    logic [1:0]        press_color;
    logic              busy;
    logic              round_ok;
    logic              round_fail;

    modport master (
        output start, round_len, seq_data,
        input  seq_addr, press_valid, press_color, busy, round_ok, round_fail
    );

    modport slave (
        input  start, round_len, seq_data,
        output seq_addr, press_valid, press_color, busy, round_ok, round_fail
    );
endinterface

// File: rtl/simon_input_checker.sv
// Simon player input path: button sync/debounce, press decode, and sequence compare.
// Optional per-press inactivity timeout is built only when SIMON_TIMEOUT_EN is defined.
//
// state        | meaning
// IDLE         | waiting for start
// FETCH        | seq_addr holds idx, memory read in flight
// LOAD         | capture expected colour from seq_data
// WAIT_PRESS   | waiting for an accepted press
// WAIT_RELEASE | waiting for all buttons released
// PASS / FAIL  | one-cycle round result pulse
module simon_input_checker #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_LEN         = 16,
    parameter int ADDR_W          = 4,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [3:0]           color,
    simon_input_checker_if.slave bus
);

    localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int             LEN_W   = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_WAIT_PRESS, S_WAIT_RELEASE, S_PASS, S_FAIL
    } state_t;

    state_t            state;
    logic [3:0]        sync1, sync2, cand, deb;
    logic [DB_W-1:0]   db_cnt;
    logic              pending;
    logic [1:0]        pend_color;
    logic [ADDR_W-1:0] idx;
    logic [LEN_W-1:0]  len;
    logic [1:0]        expected;

    function automatic logic single_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    function automatic logic [1:0] key_index(input logic [3:0] v);
        case (v)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    logic db_update, press_evt, keep_evt, consume;
    assign db_update = (sync2 == cand) && (db_cnt == DB_LAST) && (deb != cand);
    assign press_evt = db_update && (deb == 4'hF) && single_low(cand);
    // Presses landing outside a round are dropped so a button held across start never counts.
    assign keep_evt  = (state == S_FETCH) || (state == S_LOAD) ||
                       (state == S_WAIT_PRESS) || (state == S_WAIT_RELEASE);
    assign consume   = (state == S_WAIT_PRESS) && pending;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            sync1      <= 4'hF;
            sync2      <= 4'hF;
            cand       <= 4'hF;
            deb        <= 4'hF;
            db_cnt     <= '0;
            pending    <= 1'b0;
            pend_color <= 2'd0;
        end else begin
            sync1 <= color;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand   <= sync2;
                db_cnt <= '0;
            end else if (db_cnt != DB_LAST) begin
                db_cnt <= db_cnt + DB_W'(1);
            end else begin
                deb <= cand;
            end
            if (press_evt) begin
                pending    <= keep_evt;
                pend_color <= key_index(cand);
            end else if (consume || !keep_evt) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef SIMON_TIMEOUT_EN
    localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state           <= S_IDLE;
            idx             <= '0;
            len             <= '0;
            expected        <= 2'd0;
            bus.seq_addr    <= '0;
            bus.press_valid <= 1'b0;
            bus.press_color <= 2'd0;
            bus.busy        <= 1'b0;
            bus.round_ok    <= 1'b0;
            bus.round_fail  <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
            to_cnt          <= '0;
`endif
        end else begin
            bus.press_valid <= 1'b0;
            bus.round_ok    <= 1'b0;
            bus.round_fail  <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.start && (bus.round_len != '0)) begin
                        len          <= (bus.round_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                                          : bus.round_len;
                        idx          <= '0;
                        bus.seq_addr <= '0;
                        bus.busy     <= 1'b1;
                        state        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    bus.seq_addr <= idx;
                    state        <= S_LOAD;
                end
                S_LOAD: begin
                    expected <= bus.seq_data;
`ifdef SIMON_TIMEOUT_EN
                    to_cnt   <= '0;
`endif
                    state    <= S_WAIT_PRESS;
                end
                S_WAIT_PRESS: begin
                    if (pending) begin
                        bus.press_valid <= 1'b1;
                        bus.press_color <= pend_color;
                        if (pend_color != expected) begin
                            state <= S_FAIL;
                        end else if (LEN_W'(idx) == len - LEN_W'(1)) begin
                            state <= S_PASS;
                        end else begin
                            idx          <= idx + ADDR_W'(1);
                            bus.seq_addr <= idx + ADDR_W'(1);
                            state        <= S_WAIT_RELEASE;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state <= S_FAIL;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                S_WAIT_RELEASE: begin
                    if (deb == 4'hF) state <= S_FETCH;
                end
                S_PASS: begin
                    bus.round_ok <= 1'b1;
                    state        <= S_IDLE;
                end
                S_FAIL: begin
                    bus.round_fail <= 1'b1;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_input_checker.sv
// Bench for simon_input_checker: directed round table, corner sequences, random rounds vs a round model.
module tb_simon_input_checker;
    localparam int DB = 4;
    localparam int TO = 50;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] color    = 4'hF;

    simon_input_checker_if #(.ADDR_W(4)) bus ();

    simon_input_checker #(
        .DEBOUNCE_CYCLES(DB), .MAX_LEN(16), .ADDR_W(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .color(color), .bus(bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [1:0] mem [16];
    always @(posedge CLOCK_50) bus.seq_data <= mem[bus.seq_addr];

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int         pv_cyc[$];
    logic [1:0] pv_col[$];
    int         ok_cyc[$];
    int         fail_cyc[$];
    int         busy_fall[$];
    logic       busy_d = 1'b0;

    always @(negedge CLOCK_50) begin
        if (bus.press_valid) begin
            pv_cyc.push_back(cyc);
            pv_col.push_back(bus.press_color);
        end
        if (bus.round_ok)   ok_cyc.push_back(cyc);
        if (bus.round_fail) fail_cyc.push_back(cyc);
        if (busy_d && !bus.busy) busy_fall.push_back(cyc);
        busy_d = bus.busy;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic clear_mon();
        pv_cyc.delete();
        pv_col.delete();
        ok_cyc.delete();
        fail_cyc.delete();
        busy_fall.delete();
    endtask

    task automatic start_round(input int rlen);
        bus.round_len = 5'(rlen);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // t_drive is the cycle count just before the first edge that sees the clean press
    task automatic press_key(input int k, input int hold, input int gap, input int bounces,
                             output int t_drive);
        logic [3:0] low;
        low = ~(4'b0001 << k);
        for (int b = 0; b < bounces; b++) begin
            color = low;
            tick();
            color = 4'hF;
            tick();
        end
        color   = low;
        t_drive = cyc;
        tick(hold);
        color = 4'hF;
        tick(gap);
    endtask

    task automatic wait_idle(input string nm);
        int w;
        w = 0;
        while (bus.busy && w < 200) begin
            tick();
            w++;
        end
        check({nm, " busy_low"}, int'(bus.busy), 0);
    endtask

    task automatic run_round(input string nm, input int rlen, input logic [31:0] memw,
                             input logic [31:0] keys, input int nkeys, input int exp_valids,
                             input int exp_ok, input int exp_fail, input bit rnd);
        int drv[16];
        int t, n, pulse;
        for (int i = 0; i < 16; i++) mem[i] = memw[2*i +: 2];
        clear_mon();
        start_round(rlen);
        check({nm, " busy_rise"}, int'(bus.busy), 1);
        for (int i = 0; i < nkeys; i++) begin
            press_key(int'(keys[2*i +: 2]),
                      rnd ? int'($urandom_range(6, 12)) : 8,
                      rnd ? int'($urandom_range(7, 12)) : 10,
                      rnd ? int'($urandom_range(0, 3))  : 0, t);
            drv[i] = t;
        end
        wait_idle(nm);
        n = pv_cyc.size();
        check({nm, " n_press_valid"}, n, exp_valids);
        for (int i = 0; i < n && i < exp_valids; i++) begin
            check({nm, " press_color"}, int'(pv_col[i]), int'(keys[2*i +: 2]));
            check({nm, " press_latency"}, pv_cyc[i] - drv[i], DB + 4);
        end
        check({nm, " n_round_ok"}, ok_cyc.size(), exp_ok);
        check({nm, " n_round_fail"}, fail_cyc.size(), exp_fail);
        if (n > 0 && ok_cyc.size() + fail_cyc.size() == 1) begin
            pulse = (ok_cyc.size() == 1) ? ok_cyc[0] : fail_cyc[0];
            check({nm, " result_after_press"}, pulse - pv_cyc[n-1], 1);
            if (busy_fall.size() == 1)
                check({nm, " busy_fall"}, busy_fall[0] - pulse, 1);
            else
                check({nm, " n_busy_fall"}, busy_fall.size(), 1);
        end
        tick(2);
    endtask

    typedef struct {
        string       nm;
        int          rlen;
        logic [31:0] memw;
        logic [31:0] keys;
        int          nkeys;
        int          exp_valids;
        int          exp_ok;
        int          exp_fail;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, L, nk, bad;
        logic [31:0] memw, keys;
        logic [1:0]  c, k;

        bus.start     = 1'b0;
        bus.round_len = 5'd0;
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;

        vecs[0] = '{nm:"full_match",  rlen:3,  memw:32'h0000_0032, keys:32'h0000_0032, nkeys:3,  exp_valids:3,  exp_ok:1, exp_fail:0};
        vecs[1] = '{nm:"mismatch",    rlen:2,  memw:32'h0000_0005, keys:32'h0000_0009, nkeys:2,  exp_valids:2,  exp_ok:0, exp_fail:1};
        vecs[2] = '{nm:"len1_ok",     rlen:1,  memw:32'h0000_0003, keys:32'h0000_0003, nkeys:1,  exp_valids:1,  exp_ok:1, exp_fail:0};
        vecs[3] = '{nm:"first_wrong", rlen:3,  memw:32'h0000_0024, keys:32'h0000_0001, nkeys:1,  exp_valids:1,  exp_ok:0, exp_fail:1};
        vecs[4] = '{nm:"repeat3",     rlen:4,  memw:32'h0000_00FF, keys:32'h0000_00FF, nkeys:4,  exp_valids:4,  exp_ok:1, exp_fail:0};
        vecs[5] = '{nm:"clamp20",     rlen:20, memw:32'h1B1B_E4E4, keys:32'h1B1B_E4E4, nkeys:16, exp_valids:16, exp_ok:1, exp_fail:0};
        vecs[6] = '{nm:"last_wrong",  rlen:3,  memw:32'h0000_0032, keys:32'h0000_0012, nkeys:3,  exp_valids:3,  exp_ok:0, exp_fail:1};

        tick(3);
        check("rst seq_addr",    int'(bus.seq_addr), 0);
        check("rst press_valid", int'(bus.press_valid), 0);
        check("rst press_color", int'(bus.press_color), 0);
        check("rst busy",        int'(bus.busy), 0);
        check("rst round_ok",    int'(bus.round_ok), 0);
        check("rst round_fail",  int'(bus.round_fail), 0);
        reset = 1'b1;
        tick(10);

        foreach (vecs[i])
            run_round(vecs[i].nm, vecs[i].rlen, vecs[i].memw, vecs[i].keys, vecs[i].nkeys,
                      vecs[i].exp_valids, vecs[i].exp_ok, vecs[i].exp_fail, 1'b0);

        // round_len of zero is ignored
        clear_mon();
        start_round(0);
        check("len0 busy", int'(bus.busy), 0);
        tick(5);
        check("len0 busy_later", int'(bus.busy), 0);

        // bounce and multi-key vectors never produce a press
        mem[0] = 2'd0;
        clear_mon();
        start_round(1);
        for (int i = 0; i < 5; i++) begin
            color = 4'b1110;
            tick(2);
            color = 4'hF;
            tick(2);
        end
        color = 4'b1100;
        tick(20);
        color = 4'hF;
        tick(10);
        check("bounce_multi n_press_valid", pv_cyc.size(), 0);
        check("bounce_multi busy", int'(bus.busy), 1);
        press_key(0, 8, 10, 0, t);
        wait_idle("bounce_multi");
        check("bounce_multi after n_press_valid", pv_cyc.size(), 1);
        check("bounce_multi n_round_ok", ok_cyc.size(), 1);

        // button held across start is ignored until released
        mem[0] = 2'd1;
        color  = 4'b1101;
        tick(10);
        clear_mon();
        start_round(1);
        tick(30);
        check("held n_press_valid", pv_cyc.size(), 0);
        check("held busy", int'(bus.busy), 1);
        color = 4'hF;
        tick(10);
        press_key(1, 8, 10, 0, t);
        wait_idle("held");
        check("held repress n_press_valid", pv_cyc.size(), 1);
        if (pv_col.size() > 0) check("held press_color", int'(pv_col[0]), 1);
        check("held n_round_ok", ok_cyc.size(), 1);

        // press that debounces while the round is already fetching is not lost
        mem[0] = 2'd3;
        clear_mon();
        color = 4'b0111;
        tick(5);
        start_round(1);
        tick(8);
        color = 4'hF;
        tick(10);
        wait_idle("early_press");
        check("early_press n_press_valid", pv_cyc.size(), 1);
        if (pv_col.size() > 0) check("early_press press_color", int'(pv_col[0]), 3);
        check("early_press n_round_ok", ok_cyc.size(), 1);

        // reset mid-round clears everything on the next edge
        mem[0] = 2'd2;
        mem[1] = 2'd2;
        clear_mon();
        start_round(2);
        press_key(2, 8, 10, 0, t);
        check("midrst pre seq_addr", int'(bus.seq_addr), 1);
        check("midrst pre press_color", int'(bus.press_color), 2);
        reset = 1'b0;
        tick();
        check("midrst seq_addr",    int'(bus.seq_addr), 0);
        check("midrst press_color", int'(bus.press_color), 0);
        check("midrst press_valid", int'(bus.press_valid), 0);
        check("midrst busy",        int'(bus.busy), 0);
        check("midrst round_ok",    int'(bus.round_ok), 0);
        check("midrst round_fail",  int'(bus.round_fail), 0);
        reset = 1'b1;
        tick(10);

        // inactivity in WAIT_PRESS
        mem[0] = 2'd0;
        clear_mon();
        start_round(1);
`ifdef SIMON_TIMEOUT_EN
        wait_idle("timeout");
        check("timeout n_round_fail", fail_cyc.size(), 1);
        check("timeout n_press_valid", pv_cyc.size(), 0);
`else
        tick(1000);
        check("no_timeout busy", int'(bus.busy), 1);
        check("no_timeout n_round_fail", fail_cyc.size(), 0);
        check("no_timeout n_press_valid", pv_cyc.size(), 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
`endif
        tick(5);

        // random rounds against a round-level model: first wrong colour ends the round
        for (int r = 0; r < 12; r++) begin
            L    = int'($urandom_range(1, 20));
            memw = $urandom;
            keys = '0;
            nk   = 0;
            bad  = 0;
            for (int i = 0; i < ((L > 16) ? 16 : L); i++) begin
                c = memw[2*i +: 2];
                k = c;
                if ($urandom_range(0, 7) == 0) begin
                    k   = 2'(c + 2'($urandom_range(1, 3)));
                    bad = 1;
                end
                keys[2*i +: 2] = k;
                nk++;
                if (bad) break;
            end
            run_round($sformatf("rand%0d", r), L, memw, keys, nk, nk, bad ? 0 : 1, bad, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
